// File: rtl/en_bram_copy_engine.sv
// ElectronNest copy engine: a boot frame configures a block copy of N words from
// external memory into BRAM, then writes them back plus an addend to a second region.
module en_bram_copy_engine #(
  parameter int WIDTH_DATA   = 32,
  parameter int WIDTH_EXADDR = 32,
  parameter int BRAM_DEPTH   = 256
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    I_Boot,
  output logic                    O_Ld_Req,
  output logic [WIDTH_EXADDR-1:0] O_Ld_Addr,
  input  logic [WIDTH_DATA+3:0]   I_Ld_FTk,
  output logic [3:0]              O_Ld_BTk,
  output logic                    O_St_Req,
  output logic [WIDTH_EXADDR-1:0] O_St_Addr,
  output logic [WIDTH_DATA+3:0]   O_St_FTk,
  input  logic [3:0]              I_St_BTk
);

  localparam int AW = $clog2(BRAM_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_BOOT, S_LOAD, S_RD, S_WR} state_t;

  state_t state_q, state_d;

  logic [2:0]              hdr_q, hdr_d;
  logic [WIDTH_EXADDR-1:0] w0_q, w0_d;
  logic [CW-1:0]           n_q, n_d;
  logic [WIDTH_EXADDR-1:0] w2_q, w2_d;
  logic [AW-1:0]           w3_q, w3_d;
  logic [WIDTH_DATA-1:0]   w4_q, w4_d;
  logic [CW-1:0]           issued_q, issued_d;
  logic [CW-1:0]           received_q, received_d;
  logic [CW-1:0]           idx_q, idx_d;
  logic                    ld_req_q, ld_req_d;
  logic [WIDTH_EXADDR-1:0] ld_addr_q, ld_addr_d;

  logic [WIDTH_DATA-1:0]   mem [BRAM_DEPTH];
  logic [WIDTH_DATA-1:0]   bram_dout;

  // Token field views: FTk = {v,a,r,c,d}, BTk = {n,t,v,c}
  logic                  tk_v, tk_a, st_n;
  logic [WIDTH_DATA-1:0] tk_d;
  assign tk_v = I_Ld_FTk[WIDTH_DATA+3];
  assign tk_a = I_Ld_FTk[WIDTH_DATA+2];
  assign tk_d = I_Ld_FTk[WIDTH_DATA-1:0];
  assign st_n = I_St_BTk[3];

  logic unused_bits;
  assign unused_bits = ^{I_Ld_FTk[WIDTH_DATA+1:WIDTH_DATA], I_St_BTk[2:0]};

  logic          acq, boot_word, last_cfg, ld_accept, ld_done, st_last;
  logic [CW-1:0] n_cfg, ld_inflight;
  logic [AW-1:0] wr_idx, rd_idx;

  assign acq       = I_Boot & tk_v & tk_a;
  assign boot_word = (state_q == S_BOOT) & I_Boot & tk_v & ~tk_a;
  assign last_cfg  = boot_word & (hdr_q == 3'd7);
  assign n_cfg     = (tk_d > WIDTH_DATA'(BRAM_DEPTH)) ? CW'(BRAM_DEPTH) : tk_d[CW-1:0];

  // A word may only be accepted once its request has left the port (issued minus
  // the one still being presented this cycle).
  assign ld_inflight = issued_q - CW'(ld_req_q);
  assign ld_accept   = (state_q == S_LOAD) & ~acq & tk_v & (received_q < n_q) &
                       (ld_inflight > received_q);
  assign ld_done     = ld_accept & ((received_q + CW'(1)) == n_q);
  assign st_last     = (idx_q == (n_q - CW'(1)));

  assign wr_idx = w3_q + received_q[AW-1:0];
  assign rd_idx = w3_q + idx_q[AW-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (acq) begin
      state_d = S_BOOT;
    end else begin
      case (state_q)
        S_BOOT: if (last_cfg) state_d = (n_q == '0) ? S_IDLE : S_LOAD;
        S_LOAD: if (ld_done) state_d = S_RD;
        S_RD:   state_d = S_WR;
        S_WR:   if (!st_n) state_d = st_last ? S_IDLE : S_RD;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    hdr_d      = hdr_q;
    w0_d       = w0_q;
    n_d        = n_q;
    w2_d       = w2_q;
    w3_d       = w3_q;
    w4_d       = w4_q;
    issued_d   = issued_q;
    received_d = received_q;
    idx_d      = idx_q;
    ld_req_d   = 1'b0;
    ld_addr_d  = ld_addr_q;
    if (acq) begin
      hdr_d      = 3'd1;
      issued_d   = '0;
      received_d = '0;
      idx_d      = '0;
    end else begin
      if (boot_word) begin
        hdr_d = hdr_q + 3'd1;
        case (hdr_q)
          3'd3: w0_d = WIDTH_EXADDR'(tk_d);
          3'd4: n_d  = n_cfg;
          3'd5: w2_d = WIDTH_EXADDR'(tk_d);
          3'd6: w3_d = tk_d[AW-1:0];
          3'd7: begin
            w4_d       = tk_d;
            issued_d   = '0;
            received_d = '0;
            idx_d      = '0;
          end
          default: hdr_d = hdr_q + 3'd1;
        endcase
      end
      if ((state_q == S_LOAD) && (issued_q < n_q)) begin
        ld_req_d  = 1'b1;
        ld_addr_d = w0_q + WIDTH_EXADDR'(issued_q);
        issued_d  = issued_q + CW'(1);
      end
      if (ld_accept) received_d = received_q + CW'(1);
      if ((state_q == S_WR) && !st_n) idx_d = idx_q + CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hdr_q      <= '0;
      w0_q       <= '0;
      n_q        <= '0;
      w2_q       <= '0;
      w3_q       <= '0;
      w4_q       <= '0;
      issued_q   <= '0;
      received_q <= '0;
      idx_q      <= '0;
      ld_req_q   <= 1'b0;
      ld_addr_q  <= '0;
    end else begin
      hdr_q      <= hdr_d;
      w0_q       <= w0_d;
      n_q        <= n_d;
      w2_q       <= w2_d;
      w3_q       <= w3_d;
      w4_q       <= w4_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      idx_q      <= idx_d;
      ld_req_q   <= ld_req_d;
      ld_addr_q  <= ld_addr_d;
    end
  end

  // Block RAM: contents and read register are deliberately left out of reset
  always_ff @(posedge clock) begin
    if (ld_accept) mem[wr_idx] <= tk_d;
    if (state_q == S_RD) bram_dout <= mem[rd_idx];
  end

  assign O_Ld_Req  = ld_req_q;
  assign O_Ld_Addr = ld_addr_q;
  assign O_Ld_BTk  = 4'b0000;

  // bram_dout only changes in RD, so a stalled WR keeps presenting the same word
  always_comb begin
    O_St_Req  = 1'b0;
    O_St_Addr = '0;
    O_St_FTk  = '0;
    if (state_q == S_WR) begin
      O_St_Req  = 1'b1;
      O_St_Addr = w2_q + WIDTH_EXADDR'(idx_q);
      O_St_FTk  = {1'b1, 1'b0, st_last, 1'b0, bram_dout + w4_q};
    end
  end

endmodule

// File: tb/tb_en_bram_copy_engine.sv
// Bench for en_bram_copy_engine: boot frames, an external memory responder and a
// queue-based model of expected load addresses and store words.
module tb_en_bram_copy_engine;

  localparam int DW    = 32;
  localparam int XW    = 32;
  localparam int DEPTH = 256;
  localparam int FTW   = DW + 4;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           I_Boot = 1'b0;
  logic           O_Ld_Req;
  logic [XW-1:0]  O_Ld_Addr;
  logic [FTW-1:0] I_Ld_FTk = '0;
  logic [3:0]     O_Ld_BTk;
  logic           O_St_Req;
  logic [XW-1:0]  O_St_Addr;
  logic [FTW-1:0] O_St_FTk;
  logic [3:0]     I_St_BTk = '0;

  always #5 clock = ~clock;

  en_bram_copy_engine #(.WIDTH_DATA(DW), .WIDTH_EXADDR(XW), .BRAM_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .I_Boot(I_Boot),
    .O_Ld_Req(O_Ld_Req), .O_Ld_Addr(O_Ld_Addr), .I_Ld_FTk(I_Ld_FTk), .O_Ld_BTk(O_Ld_BTk),
    .O_St_Req(O_St_Req), .O_St_Addr(O_St_Addr), .O_St_FTk(O_St_FTk), .I_St_BTk(I_St_BTk)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: external memory plus expected traffic derived from the copy rules
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] d;
    logic        r;
  } st_t;

  logic [31:0] ext [logic [31:0]];
  logic [31:0] exp_ld [$];
  st_t         exp_st [$];
  logic [31:0] log_d [$];
  logic [31:0] log_addr [$];
  logic        log_r [$];
  int          ld_seen, stall_seen, last_ld_cyc;
  bit          chk_en = 1'b0;

  function automatic logic [31:0] ext_rd(input logic [31:0] a);
    if (ext.exists(a)) return ext[a];
    return 32'd0;
  endfunction

  task automatic plan(input logic [31:0] w0, input int n, input logic [31:0] w2,
                      input logic [31:0] w4);
    st_t s;
    for (int i = 0; i < n; i++) begin
      exp_ld.push_back(w0 + 32'(i));
      s.addr = w2 + 32'(i);
      s.d    = ext_rd(w0 + 32'(i)) + w4;
      s.r    = (i == n - 1);
      exp_st.push_back(s);
    end
  endtask

  // Single compare process, sampling mid-low-phase after the stimulus has settled
  always @(negedge clock) begin
    #2;
    cyc_cnt++;
    if (chk_en) begin
      check("ld_btk_zero", 64'(O_Ld_BTk), 64'd0);
      check("st_a_c_zero", 64'({O_St_FTk[34], O_St_FTk[32]}), 64'd0);
      if (O_Ld_Req) begin
        if (exp_ld.size() == 0) begin
          check("ld_unexpected", 64'(O_Ld_Addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check("ld_addr", 64'(O_Ld_Addr), 64'(exp_ld.pop_front()));
          if (last_ld_cyc >= 0) check("ld_consecutive", 64'(cyc_cnt), 64'(last_ld_cyc + 1));
        end
        last_ld_cyc = cyc_cnt;
        ld_seen++;
      end
      if (O_St_Req) begin
        if (exp_st.size() == 0) begin
          check("st_unexpected", 64'(O_St_Addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check("st_addr", 64'(O_St_Addr), 64'(exp_st[0].addr));
          check("st_data", 64'(O_St_FTk[31:0]), 64'(exp_st[0].d));
          check("st_r", 64'(O_St_FTk[33]), 64'(exp_st[0].r));
          check("st_v", 64'(O_St_FTk[35]), 64'd1);
          if (I_St_BTk[3]) begin
            stall_seen++;
          end else begin
            log_addr.push_back(O_St_Addr);
            log_d.push_back(O_St_FTk[31:0]);
            log_r.push_back(O_St_FTk[33]);
            void'(exp_st.pop_front());
          end
        end
      end else begin
        check("st_idle_zero", 64'({O_St_Addr, O_St_FTk[35:32]}) ^ 64'(O_St_FTk[31:0]), 64'd0);
      end
    end
  end

  // Stimulus-side state: memory responder and store backpressure schedule
  logic        ld_pend = 1'b0;
  logic [31:0] ld_pend_addr = '0;
  int          stall_word = -1;
  int          stall_left = 0;
  int          st_acc = 0;

  task automatic cyc(input logic use_tok, input logic [FTW-1:0] tok);
    @(negedge clock);
    I_Boot = use_tok;
    if (use_tok)      I_Ld_FTk = tok;
    else if (ld_pend) I_Ld_FTk = {4'b1000, ext_rd(ld_pend_addr)};
    else              I_Ld_FTk = '0;
    ld_pend      = O_Ld_Req;
    ld_pend_addr = O_Ld_Addr;
    I_St_BTk     = 4'b0000;
    if (O_St_Req) begin
      if (st_acc == stall_word && stall_left > 0) begin
        I_St_BTk = 4'b1000;
        stall_left--;
      end else begin
        st_acc++;
      end
    end
  endtask

  task automatic idle(input int k);
    repeat (k) cyc(1'b0, '0);
  endtask

  task automatic boot(input logic [31:0] w0, input logic [31:0] n, input logic [31:0] w2,
                      input logic [31:0] w3, input logic [31:0] w4, input bit gaps);
    logic [31:0] cfg [5];
    cfg[0] = w0; cfg[1] = n; cfg[2] = w2; cfg[3] = w3; cfg[4] = w4;
    cyc(1'b1, {4'b1100, 32'd0});
    cyc(1'b1, {4'b1000, 32'd0});
    cyc(1'b1, {4'b1000, 32'd0});
    for (int i = 0; i < 5; i++) begin
      if (gaps) cyc(1'b1, '0);
      cyc(1'b1, {4'b1000, cfg[i]});
    end
  endtask

  task automatic start_test();
    log_d.delete(); log_addr.delete(); log_r.delete();
    exp_ld.delete(); exp_st.delete();
    ld_seen = 0; stall_seen = 0; last_ld_cyc = -10;
    st_acc = 0; stall_word = -1; stall_left = 0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while ((exp_st.size() != 0 || exp_ld.size() != 0) && k < 300) begin
      cyc(1'b0, '0);
      k++;
    end
    check(name, 64'(k < 300), 64'd1);
    idle(6);
  endtask

  initial begin
    logic [31:0] want [4];

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_ld_req", 64'(O_Ld_Req), 64'd0);
    check("rst_ld_addr", 64'(O_Ld_Addr), 64'd0);
    check("rst_st_req", 64'(O_St_Req), 64'd0);
    check("rst_st_addr", 64'(O_St_Addr), 64'd0);
    check("rst_st_ftk", 64'(O_St_FTk), 64'd0);
    check("rst_ld_btk", 64'(O_Ld_BTk), 64'd0);
    reset  = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Basic copy
    start_test();
    for (int i = 0; i < 4; i++) ext[32'h10 + 32'(i)] = 32'(i + 1);
    plan(32'h10, 4, 32'h100, 32'd0);
    boot(32'h10, 32'd4, 32'h100, 32'd0, 32'd0, 1'b0);
    wait_done("t1_done");
    check("t1_ld_count", 64'(ld_seen), 64'd4);
    check("t1_st_count", 64'(log_d.size()), 64'd4);
    check("t1_addr0", 64'(log_addr[0]), 64'h100);
    check("t1_addr3", 64'(log_addr[3]), 64'h103);
    check("t1_d0", 64'(log_d[0]), 64'd1);
    check("t1_d3", 64'(log_d[3]), 64'd4);
    check("t1_r_pattern", 64'({log_r[3], log_r[2], log_r[1], log_r[0]}), 64'b1000);

    // Addend with wrapping BRAM offset
    start_test();
    for (int i = 0; i < 4; i++) ext[32'h40 + 32'(i)] = 32'(10 * (i + 1));
    plan(32'h40, 4, 32'h200, 32'd5);
    boot(32'h40, 32'd4, 32'h200, 32'(DEPTH - 2), 32'd5, 1'b0);
    wait_done("t2_done");
    want[0] = 32'd15; want[1] = 32'd25; want[2] = 32'd35; want[3] = 32'd45;
    check("t2_st_count", 64'(log_d.size()), 64'd4);
    for (int i = 0; i < 4; i++) check("t2_data", 64'(log_d[i]), 64'(want[i]));

    // Store backpressure on word 1
    start_test();
    for (int i = 0; i < 4; i++) ext[32'h80 + 32'(i)] = 32'hA0 + 32'(i);
    stall_word = 1;
    stall_left = 3;
    plan(32'h80, 4, 32'h300, 32'd1);
    boot(32'h80, 32'd4, 32'h300, 32'd8, 32'd1, 1'b0);
    wait_done("t3_done");
    check("t3_stall_cycles", 64'(stall_seen), 64'd3);
    check("t3_st_count", 64'(log_addr.size()), 64'd4);
    for (int i = 0; i < 4; i++) check("t3_addr_order", 64'(log_addr[i]), 64'(32'h300 + 32'(i)));
    check("t3_d1", 64'(log_d[1]), 64'hA2);

    // Zero length
    start_test();
    boot(32'h10, 32'd0, 32'h100, 32'd0, 32'd0, 1'b0);
    idle(20);
    check("t4_no_loads", 64'(ld_seen), 64'd0);
    check("t4_no_stores", 64'(log_d.size()), 64'd0);

    // Boot gaps give the basic-copy result
    start_test();
    plan(32'h10, 4, 32'h100, 32'd0);
    boot(32'h10, 32'd4, 32'h100, 32'd0, 32'd0, 1'b1);
    wait_done("t5_done");
    check("t5_st_count", 64'(log_d.size()), 64'd4);
    for (int i = 0; i < 4; i++) check("t5_data", 64'(log_d[i]), 64'(i + 1));

    // Asynchronous reset in the middle of LOAD
    start_test();
    for (int i = 0; i < 8; i++) ext[32'h500 + 32'(i)] = 32'(3 * i + 7);
    plan(32'h500, 8, 32'h600, 32'd0);
    boot(32'h500, 32'd8, 32'h600, 32'd0, 32'd0, 1'b0);
    idle(3);
    check("t6_loading", 64'(O_Ld_Req), 64'd1);
    chk_en = 1'b0;
    #3 reset = 1'b0;
    #1;
    check("t6_rst_ld_req", 64'(O_Ld_Req), 64'd0);
    check("t6_rst_ld_addr", 64'(O_Ld_Addr), 64'd0);
    check("t6_rst_st", 64'({O_St_Req, O_St_Addr}), 64'd0);
    check("t6_rst_st_ftk", 64'(O_St_FTk), 64'd0);
    ld_pend = 1'b0;
    idle(2);
    reset = 1'b1;
    start_test();
    chk_en = 1'b1;
    plan(32'h10, 4, 32'h100, 32'd0);
    boot(32'h10, 32'd4, 32'h100, 32'd0, 32'd0, 1'b0);
    wait_done("t6_done");
    check("t6_st_count", 64'(log_d.size()), 64'd4);
    for (int i = 0; i < 4; i++) check("t6_data", 64'(log_d[i]), 64'(i + 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
